// File: rtl/rs_dec_pkg.sv
// rs_dec_pkg: shared constants and types for the RS(255,251) lane scheduler
package rs_dec_pkg;
  localparam int NN = 255;
  localparam int KK = 251;
  localparam int TT = 2;
  typedef enum logic {IDLE, XFER} state_t;
  typedef logic [1:0] lane_t;
endpackage

// File: rtl/rs_tag_fifo.sv
// rs_tag_fifo: synchronous FIFO of lane IDs for codewords in flight in the decoder
module rs_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign head = mem[rp];
  // pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  // storage needs no reset: entries are only read once counted in
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end
endmodule

// File: rtl/rs_dec_lane_sched.sv
// rs_dec_lane_sched: round-robin sharing of one RS decoder between FRL lanes with lane-tagged results
module rs_dec_lane_sched #(
  parameter int NN        = 255,
  parameter int NLANES    = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NLANES-1:0]   lane_val,
  input  logic [NLANES-1:0]   lane_sop,
  input  logic [NLANES-1:0]   lane_eop,
  input  logic [8*NLANES-1:0] lane_din,
  output logic [NLANES-1:0]   lane_rdy,
  output logic                din_val,
  output logic                din_sop,
  output logic                din_eop,
  output logic [7:0]          din,
  input  logic                busy,
  input  logic                dec_done,
  input  logic                dec_fail,
  input  logic [1:0]          error_num,
  output logic                res_val,
  output logic [1:0]          res_lane,
  output logic                res_fail,
  output logic [1:0]          res_err_num,
  output logic                proto_err
);
  import rs_dec_pkg::*;
  state_t state, state_d;
  lane_t cur, last_grant, win, head;
  logic [7:0] cnt;
  logic [NLANES-1:0] req, stray;
  logic found, grant, acc, at_last, cw_end, pop, full, empty;
  assign req = lane_val & lane_sop;
  assign stray = lane_val & ~lane_sop;
  assign acc = state == XFER && lane_val[cur];
  assign at_last = cnt == 8'(NN-1);
  assign cw_end = acc && (lane_eop[cur] || at_last);
  assign grant = state == IDLE && found && !busy && !full;
  assign pop = dec_done || dec_fail;
  // first requester after last_grant; descending scan so the nearest one wins
  always_comb begin
    int j;
    win = last_grant;
    found = 1'b0;
    for (int k = NLANES; k >= 1; k--) begin
      j = (int'(last_grant) + k) % NLANES;
      if (req[j[1:0]]) begin
        win = j[1:0];
        found = 1'b1;
      end
    end
  end
  // ready decode: IDLE soaks up stray non-sop symbols, XFER serves only the granted lane
  always_comb begin
    lane_rdy = '0;
    for (int i = 0; i < NLANES; i++) lane_rdy[i] = state == XFER ? cur == lane_t'(i) : !lane_sop[i];
  end
  // next state
  always_comb state_d = state == IDLE ? (grant ? XFER : IDLE) : (cw_end ? IDLE : XFER);
  // FSM, grant bookkeeping and per-codeword symbol count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cur <= '0;
      last_grant <= '0;
      cnt <= '0;
    end else begin
      state <= state_d;
      if (grant) begin
        cur <= win;
        last_grant <= win;
      end
      cnt <= cw_end ? 8'd0 : cnt + 8'(acc);
    end
  end
  rs_tag_fifo #(.W(2), .DEPTH(TAG_DEPTH)) u_tags (
    .clk(clk),
    .rst_n(rst_n),
    .push(cw_end),
    .pop(pop),
    .din(cur),
    .head(head),
    .full(full),
    .empty(empty)
  );
  // single register stage for the decoder feed, results and protocol error pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_val <= 1'b0;
      din_sop <= 1'b0;
      din_eop <= 1'b0;
      din <= '0;
      res_val <= 1'b0;
      res_lane <= '0;
      res_fail <= 1'b0;
      res_err_num <= '0;
      proto_err <= 1'b0;
    end else begin
      din_val <= acc;
      din_sop <= acc && lane_sop[cur] && cnt == 8'd0;
      din_eop <= cw_end;
      din <= lane_din[8*cur +: 8];
      res_val <= pop && !empty;
      res_lane <= head;
      res_fail <= dec_fail;
      res_err_num <= dec_fail ? 2'd0 : error_num;
      proto_err <= (state == IDLE && |stray) || (acc && (lane_eop[cur] != at_last)) ||
                   (acc && lane_sop[cur] && cnt != 8'd0) || (pop && empty);
    end
  end
endmodule

// File: tb/tb_rs_dec_lane_sched.sv
// tb_rs_dec_lane_sched: scoreboard bench for the lane scheduler
module tb_rs_dec_lane_sched;
  localparam int NL = 4;
  localparam int NN = 255;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NL-1:0] lane_val, lane_sop, lane_eop, lane_rdy;
  logic [8*NL-1:0] lane_din;
  logic din_val, din_sop, din_eop;
  logic [7:0] din;
  logic busy, dec_done, dec_fail;
  logic [1:0] error_num;
  logic res_val;
  logic [1:0] res_lane;
  logic res_fail;
  logic [1:0] res_err_num;
  logic proto_err;

  rs_dec_lane_sched #(.NN(NN), .NLANES(NL), .TAG_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .lane_val(lane_val), .lane_sop(lane_sop), .lane_eop(lane_eop), .lane_din(lane_din),
    .lane_rdy(lane_rdy),
    .din_val(din_val), .din_sop(din_sop), .din_eop(din_eop), .din(din),
    .busy(busy), .dec_done(dec_done), .dec_fail(dec_fail), .error_num(error_num),
    .res_val(res_val), .res_lane(res_lane), .res_fail(res_fail), .res_err_num(res_err_num),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [7:0] d; logic s; logic e; } sym_t;
  typedef struct { int cyc; logic [1:0] l; logic f; logic [1:0] n; } res_t;
  sym_t dq[$];
  res_t rq[$];
  int tagq[$];
  int gexp[$];
  int gq[$];
  int total = 0, passed = 0, cyc_n = 0, perr_cnt = 0, exp_perr = 0;
  int pos[NL], eop_at[NL], cwid[NL];
  bit act[NL], stray[NL];
  bit auto_res = 0;
  sym_t ms;
  res_t mr;

  task automatic chk(string name, logic [31:0] a, logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, a, e);
  endtask

  function automatic logic [7:0] sym(int l, int p);
    return 8'((l * 61 + p * 3 + cwid[l] * 17) & 255);
  endfunction

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // monitor: pops expected symbols/results whenever the DUT presents one
  always @(negedge clk) begin
    if (proto_err) perr_cnt++;
    if (dq.size() > 0 && dq[0].cyc < cyc_n) begin
      ms = dq.pop_front();
      chk("din_missing", 0, 1);
    end
    if (din_val) begin
      if (dq.size() == 0) chk("din_unexpected", 1, 0);
      else begin
        ms = dq.pop_front();
        chk("din_cycle", cyc_n, ms.cyc);
        chk("din_data", {din_sop, din_eop, din}, {ms.s, ms.e, ms.d});
      end
    end
    if (rq.size() > 0 && rq[0].cyc < cyc_n) begin
      mr = rq.pop_front();
      chk("res_missing", 0, 1);
    end
    if (res_val) begin
      if (rq.size() == 0) chk("res_unexpected", 1, 0);
      else begin
        mr = rq.pop_front();
        chk("res_cycle", cyc_n, mr.cyc);
        chk("res_data", {res_lane, res_fail, res_err_num}, {mr.l, mr.f, mr.n});
      end
    end
  end

  task automatic cyc();
    bit e, last;
    for (int l = 0; l < NL; l++) begin
      lane_val[l] = act[l] | stray[l];
      lane_sop[l] = act[l] && pos[l] == 0;
      lane_eop[l] = act[l] && pos[l] == eop_at[l];
      lane_din[8*l +: 8] = act[l] ? sym(l, pos[l]) : 8'hee;
    end
    if (auto_res && tagq.size() > 0) begin
      dec_done = 1'b1;
      error_num = 2'(tagq[0] % 3);
    end
    if (dec_done || dec_fail) begin
      if (tagq.size() > 0) rq.push_back('{cyc_n + 1, 2'(tagq.pop_front()), dec_fail, dec_fail ? 2'd0 : error_num});
      else exp_perr++;
    end
    #1;
    for (int l = 0; l < NL; l++) begin
      if (lane_val[l] && lane_rdy[l]) begin
        if (act[l]) begin
          if (pos[l] == 0) begin
            gq.push_back(cyc_n);
            if (gexp.size() > 0) chk("grant_order", l, gexp.pop_front());
          end
          e = pos[l] == eop_at[l];
          last = pos[l] == NN - 1;
          dq.push_back('{cyc_n + 1, sym(l, pos[l]), pos[l] == 0, e || last});
          if (e != last) exp_perr++;
          if (e || last) begin
            act[l] = 0;
            tagq.push_back(l);
            cwid[l]++;
          end else pos[l]++;
        end else exp_perr++;
      end
      stray[l] = 0;
    end
    @(negedge clk);
    dec_done = 1'b0;
    dec_fail = 1'b0;
    error_num = 2'd0;
  endtask

  task automatic arm(int l, int ea);
    act[l] = 1;
    pos[l] = 0;
    eop_at[l] = ea;
  endtask

  task automatic run(int maxc);
    int n = 0;
    while ((act[0] | act[1] | act[2] | act[3]) && n < maxc) begin
      cyc();
      n++;
    end
    if (act[0] | act[1] | act[2] | act[3]) begin
      chk("run_timeout", 1, 0);
      for (int l = 0; l < NL; l++) act[l] = 0;
    end
  endtask

  task automatic idle(int n);
    repeat (n) cyc();
  endtask

  task automatic result(bit d, bit f, logic [1:0] en);
    dec_done = d;
    dec_fail = f;
    error_num = en;
    cyc();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, rearm, n;
    lane_val = '0; lane_sop = '0; lane_eop = '0; lane_din = '0;
    busy = 0; dec_done = 0; dec_fail = 0; error_num = 0;
    for (int l = 0; l < NL; l++) begin
      pos[l] = 0; eop_at[l] = -1; cwid[l] = 0; act[l] = 0; stray[l] = 0;
    end
    repeat (2) @(negedge clk);
    chk("reset_outs", {din_val, din_sop, din_eop, din, res_val, res_lane, res_fail, res_err_num, proto_err}, 0);
    rst_n = 1;
    #1 chk("reset_rdy_idle", lane_rdy, 4'hf);
    // single lane, clean codeword
    c0 = cyc_n;
    arm(0, NN - 1); gexp.push_back(0); run(400);
    chk("grant_latency", gq[$] - c0, 1);
    idle(2); result(1, 0, 0); idle(2);
    chk("proto_none", perr_cnt, exp_perr);
    // early eop on symbol 100
    arm(1, 99); gexp.push_back(1); run(400);
    lane_val = '0; lane_sop = '0;
    #1 chk("idle_after_eop", lane_rdy, 4'hf);
    idle(2);
    chk("proto_early_eop", perr_cnt, exp_perr);
    result(1, 0, 1); idle(2);
    // missing eop: din_eop forced on symbol 255
    arm(3, -1); gexp.push_back(3); run(400); idle(2);
    chk("proto_missing_eop", perr_cnt, exp_perr);
    result(0, 1, 2); idle(2);
    // result with empty tag FIFO, then a stray symbol in IDLE
    result(1, 0, 1); idle(2);
    chk("proto_empty_fifo", perr_cnt, exp_perr);
    stray[1] = 1; cyc(); idle(2);
    chk("proto_stray", perr_cnt, exp_perr);
    // round-robin with all lanes requesting, results returned as tags appear
    auto_res = 1; gq.delete();
    for (int l = 0; l < NL; l++) arm(l, NN - 1);
    gexp = '{0, 1, 2, 3, 0};
    rearm = 1; n = 0;
    while ((act[0] | act[1] | act[2] | act[3] | rearm != 0) && n < 2000) begin
      cyc();
      n++;
      if (!act[0] && rearm != 0) begin arm(0, NN - 1); rearm = 0; end
    end
    chk("rr_bounded", n < 2000, 1);
    idle(3); auto_res = 0;
    chk("rr_all_granted", gexp.size(), 0);
    chk("b2b_period", gq[1] - gq[0], NN + 1);
    // busy hold-off, then busy rising mid-transfer must not stall
    busy = 1; arm(2, NN - 1); gexp.push_back(2);
    repeat (8) begin
      cyc();
      chk("busy_hold", lane_rdy[2], 0);
    end
    busy = 0; cyc();
    chk("busy_release", lane_rdy[2], 1);
    idle(10); busy = 1; run(400); busy = 0;
    idle(2); result(1, 0, 2); idle(2);
    // tag FIFO full blocks the fifth grant until a result pops
    for (int k = 0; k < 4; k++) begin
      arm((k + 3) % NL, NN - 1); gexp.push_back((k + 3) % NL); run(400); idle(1);
    end
    arm(3, NN - 1); gexp.push_back(3);
    repeat (20) cyc();
    chk("full_block_pos", pos[3], 0);
    chk("full_block_rdy", lane_rdy[3], 0);
    result(0, 1, 3);
    run(400); idle(2);
    result(1, 1, 1); result(1, 0, 1); result(1, 0, 2); result(1, 0, 0); idle(2);
    chk("proto_after_full", perr_cnt, exp_perr);
    // reset mid-transfer with a stale tag in flight
    arm(2, NN - 1); gexp.push_back(2); run(400); idle(1);
    arm(0, NN - 1); gexp.push_back(0);
    n = 0;
    while (pos[0] < 119 && n < 400) begin cyc(); n++; end
    chk("mid_reach", pos[0], 119);
    rst_n = 0; act[0] = 0;
    lane_val = '0; lane_sop = '0; lane_eop = '0;
    @(negedge clk);
    chk("reset_mid_outs", {din_val, din_sop, din_eop, din, res_val, res_lane, res_fail, res_err_num, proto_err}, 0);
    rst_n = 1;
    tagq.delete(); gexp.delete();
    #1 chk("reset_mid_rdy", lane_rdy, 4'hf);
    arm(1, NN - 1); gexp.push_back(1); run(400); idle(2);
    result(1, 0, 2); idle(3);
    chk("dq_drained", dq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    chk("proto_total", perr_cnt, exp_perr);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
